// File: rtl/keypad_scan.sv
// 4x4 key matrix scanner: walks active-low rows, snapshots synchronised column
// returns once per row dwell, and debounces one key per press over full scans.
module keypad_scan #(
    parameter int SCAN_DIV = 12000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] o_row_n,
    input  logic [3:0] i_col_n,
    output logic [3:0] o_key,
    output logic       o_valid,
    output logic       o_held,
    output logic       o_release
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    logic [3:0]       col_meta;
    logic [3:0]       col_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [1:0]       row_next;
    logic [15:0]      snap;
    logic             tick;
    logic             scan_done;

    assign tick     = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign row_next = row_idx + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= 4'b1111;
            col_sync <= 4'b1111;
        end else begin
            col_meta <= i_col_n;
            col_sync <= col_meta;
        end
    end

    // Row scanning and per-row snapshot capture on the last clock of each dwell.
    // NOTE: the snapshot is only 16 flops and must be cleared so a reset discards
    // partial scan data; a larger storage array would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            row_idx   <= 2'd0;
            o_row_n   <= 4'b1110;
            snap      <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= tick && (row_idx == 2'd3);
            if (tick) begin
                div_cnt                 <= '0;
                snap[row_idx*4 +: 4]    <= ~col_sync;
                row_idx                 <= row_next;
                o_row_n                 <= ~(4'b0001 << row_next);
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Scan classification: none, exactly one key (with its code), or several.
    logic       any_set;
    logic       multi_set;
    logic [3:0] scan_code;

    always_comb begin
        any_set   = 1'b0;
        multi_set = 1'b0;
        scan_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                if (any_set) multi_set = 1'b1;
                any_set   = 1'b1;
                scan_code = 4'(i);
            end
        end
    end

    state_t           state, state_n;
    logic [3:0]       cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]       key_n;
    logic             valid_n, held_n, release_n;
    logic             is_none, is_single;

    assign is_none   = !any_set;
    assign is_single = any_set && !multi_set;
    assign cnt_inc   = cnt + 1'b1;

    // NOTE: state and registered outputs update with non-blocking assignments in
    // one clocked process; the decision logic below is purely combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= 4'd0;
            cnt       <= '0;
            o_key     <= 4'd0;
            o_valid   <= 1'b0;
            o_held    <= 1'b0;
            o_release <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            o_key     <= key_n;
            o_valid   <= valid_n;
            o_held    <= held_n;
            o_release <= release_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        cand_n    = cand;
        cnt_n     = cnt;
        key_n     = o_key;
        valid_n   = 1'b0;
        held_n    = o_held;
        release_n = 1'b0;

        if (scan_done) begin
            unique case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_n  = scan_code;
                        cnt_n   = CNT_W'(1);
                        state_n = PRESS_CHK;
                    end
                end
                PRESS_CHK: begin
                    if (is_single && scan_code == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                            key_n   = cand;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = HELD;
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        cnt_n   = CNT_W'(1);
                        state_n = RELEASE_CHK;
                    end
                end
                RELEASE_CHK: begin
                    if (is_none) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                            held_n    = 1'b0;
                            release_n = 1'b1;
                            cnt_n     = '0;
                            state_n   = IDLE;
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = HELD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3 (16 clocks per scan)
// and a behavioural 4x4 switch matrix on the row/column lines.
module tb_keypad_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] o_row_n;
    logic [3:0] i_col_n;
    logic [3:0] o_key;
    logic       o_valid;
    logic       o_held;
    logic       o_release;

    logic [15:0] keys;   // bit r*4+c set = key (r,c) pressed
    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int release_cnt = 0;
    int both_cnt = 0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .o_row_n   (o_row_n),
        .i_col_n   (i_col_n),
        .o_key     (o_key),
        .o_valid   (o_valid),
        .o_held    (o_held),
        .o_release (o_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        i_col_n = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[r*4 + c] && !o_row_n[r]) i_col_n[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (o_valid) valid_cnt++;
        if (o_release) release_cnt++;
        if (o_valid && o_release) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [3:0] one;
        logic [3:0] exp_row;
        int v0;
        one   = 4'b0001;
        rst_n = 1'b0;
        keys  = '0;
        step(3);
        if (o_row_n !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b required 1110", o_row_n); end
        checks++;
        if ({o_key, o_valid, o_held, o_release} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got key=%0d v=%b h=%b r=%b required all 0", o_key, o_valid, o_held, o_release);
        end
        checks++;
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            exp_row = ~(one << ((n / 4) % 4));
            if (o_row_n !== exp_row) begin
                errors++;
                $display("FAIL row_seq[%0d]: got %b required %b", n, o_row_n, exp_row);
            end
            checks++;
            step();
        end
        v0 = valid_cnt;
        step(320);
        if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL idle_valid: got %0d pulses required 0", valid_cnt - v0); end
        checks++;
    endtask

    task automatic test_bounce;
        int v0;
        v0 = valid_cnt;
        keys = 16'h0008;      // (0,3)
        step(32);
        keys = '0;
        step(16);
        keys = 16'h0008;
        step(32);
        keys = '0;
        step(64);
        if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL bounce_valid: got %0d pulses required 0", valid_cnt - v0); end
        checks++;
        if (o_key !== 4'd0) begin errors++; $display("FAIL bounce_key: got %0d required 0", o_key); end
        checks++;
        if (o_held !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b required 0", o_held); end
        checks++;
    endtask

    task automatic test_multi;
        int v0;
        logic seen;
        logic [3:0] k;
        v0 = valid_cnt;
        keys = 16'h0081;      // (0,0) and (1,3)
        step(160);
        if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL multi_valid: got %0d pulses required 0", valid_cnt - v0); end
        checks++;
        keys = 16'h0001;
        seen = 1'b0;
        k    = 4'hF;
        for (int i = 0; i < 64 && !seen; i++) begin
            step();
            if (o_valid) begin seen = 1'b1; k = o_key; end
        end
        if (seen !== 1'b1) begin errors++; $display("FAIL multi_single_valid: got no pulse in 64 clocks required one"); end
        checks++;
        if (k !== 4'd0) begin errors++; $display("FAIL multi_single_key: got %0d required 0", k); end
        checks++;
        keys = '0;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step();
            if (o_release) seen = 1'b1;
        end
        if (seen !== 1'b1) begin errors++; $display("FAIL multi_release: got no pulse in 64 clocks required one"); end
        checks++;
        step(32);
    endtask

    task automatic test_clean_press;
        int v0;
        logic seen;
        logic [3:0] k;
        v0   = valid_cnt;
        keys = 16'h0200;      // (2,1) -> code 9
        seen = 1'b0;
        k    = 4'hF;
        for (int i = 0; i < 64 && !seen; i++) begin
            step();
            if (o_valid) begin seen = 1'b1; k = o_key; end
        end
        if (seen !== 1'b1) begin errors++; $display("FAIL press_valid: got no pulse in 64 clocks required one"); end
        checks++;
        if (k !== 4'd9) begin errors++; $display("FAIL press_key: got %0d required 9", k); end
        checks++;
        if (o_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b required 1", o_held); end
        checks++;
        step(80);
        if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL press_single_pulse: got %0d pulses required 1", valid_cnt - v0); end
        checks++;
        if (o_held !== 1'b1) begin errors++; $display("FAIL press_held_late: got %b required 1", o_held); end
        checks++;
    endtask

    task automatic test_release_glitch;
        int v0;
        int r0;
        logic seen;
        v0 = valid_cnt;
        r0 = release_cnt;
        keys = '0;
        step(16);
        keys = 16'h0200;
        step(80);
        if (o_held !== 1'b1) begin errors++; $display("FAIL glitch_held: got %b required 1", o_held); end
        checks++;
        if (release_cnt - r0 !== 0) begin errors++; $display("FAIL glitch_release: got %0d pulses required 0", release_cnt - r0); end
        checks++;
        if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d pulses required 0", valid_cnt - v0); end
        checks++;
        keys = '0;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step();
            if (o_release) seen = 1'b1;
        end
        if (seen !== 1'b1) begin errors++; $display("FAIL release_pulse: got no pulse in 64 clocks required one"); end
        checks++;
        if (o_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b required 0", o_held); end
        checks++;
        if (o_key !== 4'd9) begin errors++; $display("FAIL release_key: got %0d required 9", o_key); end
        checks++;
        step(48);
        if (release_cnt - r0 !== 1) begin errors++; $display("FAIL release_count: got %0d pulses required 1", release_cnt - r0); end
        checks++;
    endtask

    task automatic test_async_reset;
        int v0;
        logic seen;
        logic found;
        logic [3:0] k;
        // Align to the start of a scan: row 0 driven just after row 3 was stored.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (o_row_n == 4'b0111) found = 1'b1;
        end
        for (int i = 0; i < 8 && found && o_row_n != 4'b1110; i++) step();
        if (o_row_n !== 4'b1110) begin errors++; $display("FAIL align_scan: got %b required 1110", o_row_n); end
        checks++;
        keys = 16'h0020;      // (1,1) -> code 5
        step(38);             // two matching scans accepted, third pending
        #2;
        rst_n = 1'b0;
        #1;
        if (o_row_n !== 4'b1110) begin errors++; $display("FAIL async_row: got %b required 1110", o_row_n); end
        checks++;
        if ({o_key, o_valid, o_held, o_release} !== 7'd0) begin
            errors++;
            $display("FAIL async_outputs: got key=%0d v=%b h=%b r=%b required all 0", o_key, o_valid, o_held, o_release);
        end
        checks++;
        step(3);
        rst_n = 1'b1;
        v0 = valid_cnt;
        step(47);
        if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL async_early_valid: got %0d pulses required 0", valid_cnt - v0); end
        checks++;
        seen = 1'b0;
        k    = 4'hF;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (o_valid) begin seen = 1'b1; k = o_key; end
        end
        if (seen !== 1'b1) begin errors++; $display("FAIL async_requalify: got no pulse in window required one"); end
        checks++;
        if (k !== 4'd5) begin errors++; $display("FAIL async_key: got %0d required 5", k); end
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL valid_release_overlap: got %0d cycles required 0", both_cnt); end
        checks++;
    endtask

    initial begin
        rst_n = 1'b0;
        keys  = '0;
        test_reset();
        test_bounce();
        test_multi();
        test_clean_press();
        test_release_glitch();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart to the LED matrix scanner: drives the rows of a 4x4 key matrix active-low, one row at a time.
- Senses the active-low column returns and resolves one debounced key per press.
- Reports each press as a key code with a one-cycle valid strobe, plus a held level and a release strobe.
- Runs on the board system clock beside the display/scroll path. Its key events feed text-selection and scroll-control logic.

Parameters:
SCAN_DIV, 12000, clocks per row dwell (1 ms at 12 MHz); minimum 4
DEBOUNCE, 4, consecutive identical full scans needed to accept a press or a release; minimum 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
o_row_n  output  4  row drive, active-low, exactly one bit low at all times
i_col_n  input  4  column sense, active-low, externally pulled up, asynchronous
o_key  output  4  key code = row*4 + col of the last accepted press
o_valid  output  1  one-cycle pulse when a press is accepted
o_held  output  1  high from press acceptance until release acceptance
o_release  output  1  one-cycle pulse when a release is accepted

Behaviour:
- Reset (async assert, sync release): o_row_n=4'b1110, row index=0, dwell counter=0, column synchroniser=4'b1111, scan snapshot cleared, FSM=IDLE, o_key=0, o_valid=0, o_held=0, o_release=0.
- i_col_n passes through a 2-FF synchroniser; the synchroniser resets to 4'b1111.
- Dwell counter runs 0..SCAN_DIV-1 and wraps. Tick = counter at SCAN_DIV-1.
- On each tick:
  - store the inverted, synchronised columns into the snapshot slot for the current row;
  - advance the row index mod 4;
  - o_row_n = ~(1 << new index), so the sequence is 1110, 1101, 1011, 0111, then wraps.
- The tick that stores row 3 completes a scan.
- Scan classification is made on the completed 16-bit snapshot:
  - NONE: all bits zero;
  - SINGLE(c): exactly one bit set, c = row*4 + col;
  - MULTI: two or more bits set.
- The FSM advances on the clock edge after scan completion, i.e. once per scan. Counter cnt is 0..DEBOUNCE.
- IDLE:
  - SINGLE(c): cand=c, cnt=1, go to PRESS_CHK.
  - NONE or MULTI: stay in IDLE.
- PRESS_CHK:
  - SINGLE(cand): cnt+1. If that reaches DEBOUNCE: o_key=cand, o_valid=1 for one cycle, o_held=1, go to HELD.
  - NONE, MULTI, or a different SINGLE: go to IDLE, cnt=0. A different key restarts only from the next scan.
- HELD:
  - NONE: cnt=1, go to RELEASE_CHK.
  - SINGLE of any key or MULTI: stay in HELD. No new o_valid while held (no rollover).
- RELEASE_CHK:
  - NONE: cnt+1. If that reaches DEBOUNCE: o_held=0, o_release=1 for one cycle, go to IDLE. o_key keeps its value.
  - Anything else: return to HELD, cnt=0.
- Latency: o_valid rises one clock after the FSM edge that accepts the DEBOUNCE-th matching scan. Minimum press-to-valid time is DEBOUNCE*4*SCAN_DIV plus at most one scan of phase, plus 2–3 clocks.
- o_valid and o_release are never high in the same cycle. o_key changes only in the cycle o_valid rises.
- Reset mid-operation discards the snapshot and debounce progress immediately. A press in progress must re-qualify for DEBOUNCE full scans after reset release.
- Column sample point is the last clock of the dwell, giving SCAN_DIV-3 clocks of settling after a row change.

Test Plan:
- Use SCAN_DIV=4, DEBOUNCE=3 (one scan = 16 clocks). The bench matrix model pulls i_col_n[c] low while o_row_n[r]=0 for each pressed key (r,c).
- Reset/idle:
  - hold rst_n low, then release with no key pressed;
  - required: all outputs 0, o_row_n=1110 during reset;
  - o_row_n then steps 1110, 1101, 1011, 0111 every 4 clocks and wraps;
  - o_valid never pulses over 20 scans.
- Clean press:
  - press (2,1) and hold;
  - required: exactly one o_valid pulse with o_key=9, arriving within 4 scans of the press;
  - o_held=1 from that cycle onward, with no further o_valid.
- Bounce:
  - press (0,3) for 2 full scans, release for 1 scan, press again for 2 scans, release;
  - required: no o_valid, o_key stays 0, o_held stays 0.
- Multi-key:
  - press (0,0) and (1,3) together for 10 scans;
  - required: no o_valid;
  - then release (1,3) only: o_valid with o_key=0 within 4 scans.
- Release with glitch:
  - from HELD on key 9, drop the key for 1 scan, then restore it;
  - required: o_held stays 1, no o_release, no o_valid;
  - then release fully: one o_release pulse within 4 scans, o_held=0, o_key stays 9.
- Async reset mid-debounce:
  - pull rst_n low for 3 clocks while in PRESS_CHK with cnt=2 on key 5;
  - required: outputs reset immediately, o_row_n=1110;
  - with the key still held, o_valid (o_key=5) reappears only after 3 full post-reset scans.
